// File: rtl/pwm_demod.sv
// pwm_demod: recovers a WIDTH-bit sample from a PWM stream by counting the
// high cycles inside each PERIOD-cycle frame. It locks onto frame phase
// after LOCK_WINDOWS clean frames and emits one sample per frame with a
// valid/ready handshake. Newer samples overwrite older unconsumed ones.
// Optional build macro PWM_DEMOD_GLITCH_FILTER_EN removes single-cycle
// pulses from the synced input.
module pwm_demod #(
    parameter int WIDTH        = 8,
    parameter int PERIOD       = 256,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_WINDOWS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic             locked_o,
    output logic             overrun_o
);

    localparam int CW = $clog2(LOCK_WINDOWS + 1);

    typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_pwm;
    logic                   r_pwm_d1;
    logic                   w_rise;
    logic [WIDTH-1:0]       r_win_cnt;
    logic [WIDTH:0]         r_high_cnt;
    logic [CW-1:0]          r_clean_cnt;
    logic                   w_win_end;
    logic                   w_phase_err;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_result;
    logic                   w_emit;
    logic [WIDTH-1:0]       r_sample;
    logic                   r_valid;
    logic                   r_overrun;

    // Input synchronizer chain; the last stage is the synced level
    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_i};
    end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    logic r_filt;

    // Filter output follows the synced level only once two consecutive synced
    // samples agree; using the next-to-last stage keeps the delay at one cycle
    always_ff @(posedge clk) begin
        if (reset)
            r_filt <= 1'b0;
        else if (r_sync[SYNC_STAGES-2] == r_sync[SYNC_STAGES-1])
            r_filt <= r_sync[SYNC_STAGES-2];
    end

    assign w_pwm = r_filt;
`else
    assign w_pwm = r_sync[SYNC_STAGES-1];
`endif

    // Delayed copy of the working level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) r_pwm_d1 <= 1'b0;
        else       r_pwm_d1 <= w_pwm;
    end

    assign w_rise      = w_pwm & ~r_pwm_d1;
    assign w_win_end   = (r_win_cnt == WIDTH'(PERIOD - 1));
    assign w_phase_err = w_rise && (r_win_cnt != '0) && (r_state != SEEK);
    assign w_sum       = r_high_cnt + (WIDTH + 1)'(w_pwm);
    assign w_result    = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    assign w_emit      = (r_state == LOCKED) && w_win_end && !w_phase_err;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= SEEK;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic; disable always returns to SEEK
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEEK:    if (w_rise) w_state_next = TRACK;
            TRACK:   if (!w_phase_err && w_win_end &&
                         (r_clean_cnt == CW'(LOCK_WINDOWS - 1)))
                         w_state_next = LOCKED;
            LOCKED:  if (w_phase_err) w_state_next = TRACK;
            default: w_state_next = SEEK;
        endcase
        if (!en) w_state_next = SEEK;
    end

    // FSM outputs
    always_comb begin
        locked_o = (r_state == LOCKED);
    end

    // Frame window, high-time and clean-frame counters
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_win_cnt   <= '0;
            r_high_cnt  <= '0;
            r_clean_cnt <= '0;
        end else if (r_state == SEEK) begin
            if (w_rise) begin
                r_win_cnt   <= WIDTH'(1);
                r_high_cnt  <= (WIDTH + 1)'(1);
                r_clean_cnt <= '0;
            end
        end else if (w_phase_err) begin
            r_win_cnt   <= WIDTH'(1);
            r_high_cnt  <= (WIDTH + 1)'(1);
            r_clean_cnt <= '0;
        end else if (w_win_end) begin
            r_win_cnt  <= '0;
            r_high_cnt <= '0;
            if (r_state == TRACK) r_clean_cnt <= r_clean_cnt + CW'(1);
        end else begin
            r_win_cnt  <= r_win_cnt + WIDTH'(1);
            r_high_cnt <= w_sum;
        end
    end

    // Output sample register and handshake; disable keeps the last sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!en) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_emit) begin
                r_sample  <= w_result;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~sample_ready_i;
            end else if (r_valid && sample_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
    assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: drives PWM frames into pwm_demod and scores recovered
// samples against a queue of expected values and arrival cycles.
module tb_pwm_demod;

    localparam int P  = 256;
    localparam int SS = 2;
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    localparam int LAT  = SS + 1;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = SS;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       pwm_i = 1'b0;
    logic       sample_ready_i = 1'b1;
    logic [7:0] sample_o;
    logic       sample_valid_o;
    logic       locked_o;
    logic       overrun_o;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned ovr_seen = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;

    typedef struct {
        logic [7:0]  val;
        int unsigned at;
    } exp_t;
    exp_t sb[$];

    pwm_demod #(
        .WIDTH(8),
        .PERIOD(P),
        .SYNC_STAGES(SS),
        .LOCK_WINDOWS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .pwm_i(pwm_i),
        .sample_o(sample_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .locked_o(locked_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A new sample is visible when valid is high and the previous cycle either
    // had no sample, completed a transfer, or this cycle reports an overwrite.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (overrun_o) ovr_seen++;
        if (sample_valid_o && (!prev_valid || prev_ready || overrun_o)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sample: got %02h at cycle %0d, required no sample", sample_o, cyc);
            end else begin
                e = sb.pop_front();
                if (sample_o !== e.val || cyc != e.at) begin
                    failures++;
                    $display("FAIL sample: got %02h at cycle %0d, required %02h at cycle %0d",
                             sample_o, cyc, e.val, e.at);
                end
            end
        end
        prev_valid = sample_valid_o;
        prev_ready = sample_ready_i;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic drive_cycle(input logic v);
        pwm_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sample(input logic [7:0] v, input int unsigned at);
        exp_t e;
        e.val = v;
        e.at  = at;
        sb.push_back(e);
    endtask

    // The window of a frame started now ends P cycles later plus the input latency.
    task automatic send_frame(input int s, input int len, input bit emit, input logic [7:0] v);
        if (emit) expect_sample(v, cyc + P + LAT);
        for (int j = 0; j < len; j++) drive_cycle(j < s);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sample_o !== 8'h00 || sample_valid_o !== 1'b0 || locked_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got s=%02h v=%b l=%b o=%b, required all 0",
                     sample_o, sample_valid_o, locked_o, overrun_o);
        end
        reset = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Two clean frames after the first rise, then a third whose sample is emitted.
    task automatic test_relock(input logic [7:0] v);
        int unsigned start;
        send_frame(v, P, 1'b0, v);
        send_frame(v, P, 1'b0, v);
        start = cyc;
        expect_sample(v, start + P + LAT);
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < v);
            if (j == LAT - 2) begin
                checks++;
                if (locked_o !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_early: got locked=%b, required 0", locked_o);
                end
            end
            if (j == LAT - 1) begin
                checks++;
                if (locked_o !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_rise: got locked=%b, required 1", locked_o);
                end
            end
        end
    endtask

    task automatic test_lock();
        int vcnt;
        test_relock(8'h80);
        send_frame(128, P, 1'b1, 8'h80);
        vcnt = 0;
        expect_sample(8'h80, cyc + P + LAT);
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < 128);
            if (sample_valid_o) vcnt++;
        end
        checks++;
        if (vcnt != 1) begin
            failures++;
            $display("FAIL valid_pulse: got %0d valid cycles in a frame, required 1", vcnt);
        end
    endtask

    task automatic test_boundary();
        send_frame(1,   P, 1'b1, FILT ? 8'h00 : 8'h01);
        send_frame(255, P, 1'b1, 8'hFF);
        send_frame(0,   P, 1'b1, 8'h00);
        send_frame(P,   P, 1'b1, 8'hFF);
        send_frame(128, P, 1'b1, 8'h80);
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL boundary_lock: got locked=%b, required 1", locked_o);
        end
    endtask

    task automatic test_backpressure();
        int          bad;
        int unsigned ovr0;
        send_frame(0, 0, 1'b1, 8'h10);
        for (int j = 0; j < P; j++) begin
            if (j == 10) sample_ready_i = 1'b0;
            drive_cycle(j < 16);
        end
        bad  = 0;
        ovr0 = ovr_seen;
        expect_sample(8'h20, cyc + P + LAT);
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < 32);
            if (j >= LAT && (sample_valid_o !== 1'b1 || sample_o !== 8'h10)) bad++;
        end
        expect_sample(8'h80, cyc + P + LAT);
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < 128);
            if (j < 20 && sample_valid_o !== 1'b1) bad++;
            if (j == 19) begin
                checks++;
                if (ovr_seen - ovr0 != 1) begin
                    failures++;
                    $display("FAIL overrun_count: got %0d pulses, required 1", ovr_seen - ovr0);
                end
                sample_ready_i = 1'b1;
            end
            if (j == 20) begin
                checks++;
                if (sample_valid_o !== 1'b0 || sample_o !== 8'h20) begin
                    failures++;
                    $display("FAIL ready_release: got v=%b s=%02h, required v=0 s=20",
                             sample_valid_o, sample_o);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_under_backpressure: got %0d bad cycles, required 0", bad);
        end
    endtask

    // The stretched frame's window still closes after P cycles and is emitted;
    // the partial window cut short by the late rise is dropped.
    task automatic test_phase_slip();
        send_frame(128, P + 3, 1'b1, 8'h80);
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < 128);
            if (j == LAT - 1) begin
                checks++;
                if (locked_o !== 1'b1) begin
                    failures++;
                    $display("FAIL slip_before: got locked=%b, required 1", locked_o);
                end
            end
            if (j == LAT) begin
                checks++;
                if (locked_o !== 1'b0) begin
                    failures++;
                    $display("FAIL slip_drop: got locked=%b, required 0", locked_o);
                end
            end
        end
        send_frame(128, P, 1'b0, 8'h00);
        expect_sample(8'h80, cyc + P + LAT);
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < 128);
            if (j == LAT - 2 || j == LAT - 1) begin
                checks++;
                if (locked_o !== (j == LAT - 1)) begin
                    failures++;
                    $display("FAIL slip_relock: got locked=%b at j=%0d, required %b",
                             locked_o, j, (j == LAT - 1));
                end
            end
        end
        send_frame(8'h33, P, 1'b1, 8'h33);
    endtask

    task automatic test_glitch();
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
        expect_sample(8'h40, cyc + P + LAT);
        for (int j = 0; j < P; j++) drive_cycle(j < 64 && j != 20);
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL glitch_lock: got locked=%b, required 1", locked_o);
        end
        send_frame(8'h40, P, 1'b1, 8'h40);
`else
        for (int j = 0; j < P; j++) begin
            drive_cycle(j < 64 && j != 20);
            if (j == 20 + LAT || j == 21 + LAT) begin
                checks++;
                if (locked_o !== (j == 20 + LAT)) begin
                    failures++;
                    $display("FAIL glitch_phase_err: got locked=%b at j=%0d, required %b",
                             locked_o, j, (j == 20 + LAT));
                end
            end
        end
        test_relock(8'h40);
`endif
    endtask

    task automatic test_en();
        send_frame(8'h5A, P, 1'b1, 8'h5A);
        sample_ready_i = 1'b0;
        for (int j = 0; j < P; j++) begin
            if (j == 100) begin
                checks++;
                if (sample_valid_o !== 1'b1 || locked_o !== 1'b1) begin
                    failures++;
                    $display("FAIL en_pre: got v=%b l=%b, required v=1 l=1", sample_valid_o, locked_o);
                end
                en = 1'b0;
            end
            drive_cycle(j < 128);
            if (j == 100) begin
                checks++;
                if (sample_valid_o !== 1'b0 || locked_o !== 1'b0 || sample_o !== 8'h5A) begin
                    failures++;
                    $display("FAIL en_low: got v=%b l=%b s=%02h, required v=0 l=0 s=5A",
                             sample_valid_o, locked_o, sample_o);
                end
                sample_ready_i = 1'b1;
            end
        end
        en = 1'b1;
        test_relock(8'hC3);
    endtask

    task automatic test_reset_mid();
        sample_ready_i = 1'b0;
        for (int j = 0; j < P; j++) begin
            if (j == 50) begin
                checks++;
                if (sample_valid_o !== 1'b1 || sample_o !== 8'hC3) begin
                    failures++;
                    $display("FAIL reset_pre: got v=%b s=%02h, required v=1 s=C3", sample_valid_o, sample_o);
                end
                reset = 1'b1;
            end
            drive_cycle(j < 128);
            if (j == 50) begin
                checks++;
                if (sample_o !== 8'h00 || sample_valid_o !== 1'b0 || locked_o !== 1'b0 || overrun_o !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid: got s=%02h v=%b l=%b o=%b, required all 0",
                             sample_o, sample_valid_o, locked_o, overrun_o);
                end
                sample_ready_i = 1'b1;
            end
        end
        reset = 1'b0;
        test_relock(8'h6C);
        for (int j = 0; j < LAT + 4; j++) drive_cycle(1'b0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_samples: got %0d outstanding, required 0", sb.size());
        end
        checks++;
        if (ovr_seen != 1) begin
            failures++;
            $display("FAIL total_overrun: got %0d pulses, required 1", ovr_seen);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_boundary();
        test_backpressure();
        test_phase_slip();
        test_glitch();
        test_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
